instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the 16-bit processor: holds the program counter, issues single-outstanding requests to instruction memory, and registers the returned 16-bit word for the decode/control stage. The `opcode` output drives the control unit directly. The stage redirects on branch/jump resolution from downstream and discards stale responses. Single clock domain, one instruction buffered.

## Interface
- `PC_W`, 16: program-counter width, word-addressed.
- `RESET_PC`, 0: PC value loaded at reset.
- `clock` in 1: stage clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request; held until `imem_ack`.
- `imem_addr` out PC_W: fetch address; stable while `imem_req`=1.
- `imem_ack` in 1: response valid; may assert in the same cycle as `imem_req` (zero-wait memory).
- `imem_rdata` in 16: instruction word, valid with `imem_ack`.
- `instr_valid` out 1: `instr` holds a valid instruction.
- `instr_ready` in 1: decode accepts `instr` this cycle.
- `instr` out 16: registered instruction.
- `opcode` out 4: `instr[15:12]`, to the control unit.
- `instr_pc` out PC_W: address of `instr`.
- `redirect` in 1: one-cycle pulse; taken branch/jump resolved downstream.
- `redirect_target` in PC_W: new fetch address, valid with `redirect`.
- `instr_jumped` out 1: present only with `IFETCH_JUMP_PREDECODE_EN`; see Configuration.

## Operation
- State machine: S_REQ (request outstanding), S_FULL (instruction held for decode). Internal `pc` and `stale` flag.
- S_REQ:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack` with `stale`=0: latch `imem_rdata` to `instr`, `pc` to `instr_pc`; set `instr_valid`=1; `pc`<=`pc`+1; go S_FULL.
  - On `imem_ack` with `stale`=1: discard data, clear `stale`, stay S_REQ (new address next cycle).
- S_FULL:
  - `imem_req`=0.
  - On `instr_ready`: `instr_valid`<=0; go S_REQ.
- `redirect` has top priority and is applied the same cycle:
  - S_FULL: held instruction is dropped (`instr_valid`<=0), `pc`<=target, go S_REQ. If `instr_ready` is also high, the handshake counts as completed.
  - S_REQ with `imem_ack` same cycle: data discarded, `pc`<=target, stay S_REQ.
  - S_REQ without ack: the address stays stable (request must complete), `stale`<=1, `pc`<=target. A later redirect while stale only updates `pc`.
- `pc`+1 wraps modulo 2^PC_W (0xFFFF -> 0x0000 for PC_W=16).
- `opcode` is combinational from `instr` register; it is meaningful only when `instr_valid`=1.

## Timing
- Reset values: `pc`=RESET_PC, state S_REQ, `stale`=0, `imem_req`=0 during reset, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=16'h0000, `opcode`=4'h0, `instr_pc`=0, `instr_jumped`=0.
- First request asserts in the first cycle after `reset_n` deasserts.
- Latency: ack in cycle N -> `instr_valid`=1 in N+1. Peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- Reset asserted mid-request: state clears immediately. The memory must tolerate an abandoned request.

## Configuration
- `IFETCH_JUMP_PREDECODE_EN` defined:
  - A non-stale ack whose `imem_rdata[15:12]`=4'b0000 (jump) sets next `pc`={`pc`[PC_W-1:12], `imem_rdata`[11:0]} instead of `pc`+1.
  - `instr_jumped`=1 alongside that `instr`. Downstream suppresses its redirect for that jump.
  - An external redirect still overrides.
- Not defined: jumps fetch sequentially and are resolved only by `redirect`. The `instr_jumped` port is absent.

## Structure
- Package `ifetch_pkg`:
  - state enum.
  - `INSTR_W`=16.
  - opcode constants OP_JUMP=4'b0000, OP_RTYPE=4'b0001, OP_LW=4'b0010, OP_SW=4'b0011, OP_BRANCH=4'b0100.
- Optional sub-module `ifetch_predecode`: combinational jump detection and target formation. It is instantiated only under the macro.

## Test plan
- Reset release, zero-wait memory returning 0x1234 @0, 0x2345 @1, `instr_ready`=1:
  - `imem_addr` 0,1,2 on alternating cycles.
  - `instr`/`opcode`/`instr_pc` = 0x1234/1/0 then 0x2345/2/1.
- `instr_ready`=0 for 5 cycles:
  - `instr_valid` stays 1 with `instr` unchanged.
  - `imem_req`=0 throughout.
- 3-cycle memory latency, `redirect` to 0x0040 in cycle 1 of the request:
  - `imem_addr` holds until ack.
  - Data discarded, `instr_valid` stays 0.
  - Next request at 0x0040.
- `redirect` to 0x0100 while S_FULL, simultaneous `instr_ready`:
  - `instr_valid` drops.
  - Next `imem_addr`=0x0100.
- `RESET_PC`=0xFFFF: second fetch address = 0x0000.
- With macro, word 0x0ABC fetched at `pc`=0x1005:
  - `instr_jumped`=1.
  - Next `imem_addr`=0x1ABC.

Source files
------------

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared types and constants for the instruction-fetch stage:
//               FSM state encoding, instruction width and the major opcode
//               values decoded from instr[15:12].
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_JUMP   = 4'b0000;
  localparam logic [3:0] OP_RTYPE  = 4'b0001;
  localparam logic [3:0] OP_LW     = 4'b0010;
  localparam logic [3:0] OP_SW     = 4'b0011;
  localparam logic [3:0] OP_BRANCH = 4'b0100;

  // S_REQ  : a fetch request is outstanding to instruction memory
  // S_FULL : one instruction is held for the decode stage
  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_FULL = 1'b1
  } ifetch_state_e;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/ifetch_predecode.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_predecode
// Description : Combinational jump pre-decode. Flags a returned word whose
//               opcode is OP_JUMP and forms the jump target by replacing the
//               low 12 bits of the current PC with the instruction's
//               immediate field. Only instantiated when
//               IFETCH_JUMP_PREDECODE_EN is defined.
// Ports       : pc_i      - address the word was fetched from
//               rdata_i   - returned instruction word
//               is_jump_o - word is a jump
//               target_o  - {pc_i[PC_W-1:12], rdata_i[11:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_predecode
  import ifetch_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] rdata_i,
  output logic               is_jump_o,
  output logic [PC_W-1:0]    target_o
);

  assign is_jump_o = (rdata_i[15:12] == OP_JUMP);

  // Page-relative jump: upper PC bits are kept, low 12 bits come from the word.
  always_comb begin
    target_o       = pc_i;
    target_o[11:0] = rdata_i[11:0];
  end

endmodule : ifetch_predecode
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction-fetch stage. Holds the PC, issues one outstanding
//               request at a time to instruction memory and registers the
//               returned word for decode. Downstream redirects take top
//               priority; a redirect that arrives while a request is still
//               in flight marks the response stale so it is discarded.
//               Optional macro IFETCH_JUMP_PREDECODE_EN enables local jump
//               pre-decode and the instr_jumped output.
// Ports       : clock/reset_n           - clock, async active-low reset
//               imem_req/addr/ack/rdata - instruction memory handshake
//               instr_valid/ready       - handshake to decode
//               instr/opcode/instr_pc   - held instruction, opcode, address
//               redirect/redirect_target- downstream PC redirect
//               instr_jumped            - (macro only) held instr was a
//                                         locally resolved jump
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target
`ifdef IFETCH_JUMP_PREDECODE_EN
  ,
  output logic               instr_jumped
`endif
);

  ifetch_state_e      state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;      // address of a request made stale
  logic               stale_q, stale_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic [PC_W-1:0]    w_seq_pc;
  logic [PC_W-1:0]    w_fetch_next_pc;

  assign w_seq_pc = pc_q + PC_W'(1);

`ifdef IFETCH_JUMP_PREDECODE_EN
  logic            jumped_q, jumped_d;
  logic            w_is_jump;
  logic [PC_W-1:0] w_jump_target;

  ifetch_predecode #(
    .PC_W (PC_W)
  ) u_predecode (
    .pc_i      (pc_q),
    .rdata_i   (imem_rdata),
    .is_jump_o (w_is_jump),
    .target_o  (w_jump_target)
  );

  assign w_fetch_next_pc = w_is_jump ? w_jump_target : w_seq_pc;
  assign instr_jumped    = jumped_q;
`else
  assign w_fetch_next_pc = w_seq_pc;
`endif

  // Request is forced low while reset is held so an abandoned request is
  // withdrawn immediately.
  assign imem_req    = (state_q == S_REQ) && reset_n;
  // While stale, the in-flight address must stay on the bus even though the
  // PC has already moved to the redirect target.
  assign imem_addr   = stale_q ? addr_q : pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[15:12];
  assign instr_pc    = instr_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    stale_d    = stale_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
`ifdef IFETCH_JUMP_PREDECODE_EN
    jumped_d   = jumped_q;
`endif
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = redirect_target;
          if (imem_ack) begin
            // Response ends the outstanding request; data is dropped.
            stale_d = 1'b0;
          end else if (!stale_q) begin
            stale_d = 1'b1;
            addr_d  = pc_q;
          end
        end else if (imem_ack) begin
          if (stale_q) begin
            stale_d = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = w_fetch_next_pc;
            state_d    = S_FULL;
`ifdef IFETCH_JUMP_PREDECODE_EN
            jumped_d   = w_is_jump;
`endif
          end
        end
      end
      S_FULL: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = redirect_target;
          state_d = S_REQ;
`ifdef IFETCH_JUMP_PREDECODE_EN
          jumped_d = 1'b0;
`endif
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = S_REQ;
`ifdef IFETCH_JUMP_PREDECODE_EN
          jumped_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      stale_q    <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
`ifdef IFETCH_JUMP_PREDECODE_EN
      jumped_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      stale_q    <= stale_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
`ifdef IFETCH_JUMP_PREDECODE_EN
      jumped_q   <= jumped_d;
`endif
    end
  end

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch. Two instances
//               share clock/reset: the main one (RESET_PC=0) and a second one
//               (RESET_PC=0xFFFF) that exercises PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        zw;          // main memory model: 1 = zero-wait, 0 = manual
  logic        man_ack;
  logic [15:0] man_rdata;
  logic        redir;
  logic [15:0] redir_tgt;

  logic        req, ack, vld;
  logic [15:0] addr, rdata, ins, ipc;
  logic [3:0]  opc;
  logic        req2, vld2;
  logic [15:0] addr2, rdata2, ins2, ipc2;
  logic [3:0]  opc2;
`ifdef IFETCH_JUMP_PREDECODE_EN
  logic        jmp, jmp2;
`endif

  int checks;
  int failures;
  logic [15:0] exp_next;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1234;
      16'h0001: mem_word = 16'h2345;
      16'h1005: mem_word = 16'h0ABC;
      default:  mem_word = 16'h3000 | {4'h0, a[11:0]};
    endcase
  endfunction

  always_comb begin
    ack    = zw ? req : man_ack;
    rdata  = zw ? mem_word(addr) : man_rdata;
    rdata2 = mem_word(addr2);
  end

  instr_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clock           (clk),
    .reset_n         (rst_n),
    .imem_req        (req),
    .imem_addr       (addr),
    .imem_ack        (ack),
    .imem_rdata      (rdata),
    .instr_valid     (vld),
    .instr_ready     (ready),
    .instr           (ins),
    .opcode          (opc),
    .instr_pc        (ipc),
    .redirect        (redir),
    .redirect_target (redir_tgt)
`ifdef IFETCH_JUMP_PREDECODE_EN
    ,
    .instr_jumped    (jmp)
`endif
  );

  instr_fetch #(.PC_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .clock           (clk),
    .reset_n         (rst_n),
    .imem_req        (req2),
    .imem_addr       (addr2),
    .imem_ack        (req2),
    .imem_rdata      (rdata2),
    .instr_valid     (vld2),
    .instr_ready     (ready),
    .instr           (ins2),
    .opcode          (opc2),
    .instr_pc        (ipc2),
    .redirect        (1'b0),
    .redirect_target (16'h0000)
`ifdef IFETCH_JUMP_PREDECODE_EN
    ,
    .instr_jumped    (jmp2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    ready     = 1'b1;
    zw        = 1'b1;
    man_ack   = 1'b0;
    man_rdata = 16'h0000;
    redir     = 1'b0;
    redir_tgt = 16'h0000;

    // Reset state
    tick();
    tick();
    chk("rst_req",    {31'd0, req}, 32'd0);
    chk("rst_addr",   {16'd0, addr}, 32'h0000);
    chk("rst_valid",  {31'd0, vld}, 32'd0);
    chk("rst_instr",  {16'd0, ins}, 32'h0000);
    chk("rst_opcode", {28'd0, opc}, 32'h0);
    chk("rst_ipc",    {16'd0, ipc}, 32'h0000);
    chk("rst2_addr",  {16'd0, addr2}, 32'hFFFF);
`ifdef IFETCH_JUMP_PREDECODE_EN
    chk("rst_jumped", {31'd0, jmp}, 32'd0);
`endif

    // Release: first request in the first cycle after reset
    rst_n = 1'b1;
    #1;
    chk("f0_req",   {31'd0, req}, 32'd1);
    chk("f0_addr",  {16'd0, addr}, 32'h0000);
    chk("f0_valid", {31'd0, vld}, 32'd0);
    chk("f0_addr2", {16'd0, addr2}, 32'hFFFF);

    tick();
    chk("f0_dvalid", {31'd0, vld}, 32'd1);
    chk("f0_instr",  {16'd0, ins}, 32'h1234);
    chk("f0_opcode", {28'd0, opc}, 32'h1);
    chk("f0_ipc",    {16'd0, ipc}, 32'h0000);
    chk("f0_reqlo",  {31'd0, req}, 32'd0);

    tick();
    chk("f1_req",   {31'd0, req}, 32'd1);
    chk("f1_addr",  {16'd0, addr}, 32'h0001);
    chk("wrap_req2",  {31'd0, req2}, 32'd1);
    chk("wrap_addr2", {16'd0, addr2}, 32'h0000);

    tick();
    chk("f1_instr",  {16'd0, ins}, 32'h2345);
    chk("f1_opcode", {28'd0, opc}, 32'h2);
    chk("f1_ipc",    {16'd0, ipc}, 32'h0001);

    // Decode stall for 5 cycles
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, vld}, 32'd1);
      chk("stall_instr", {16'd0, ins}, 32'h2345);
      chk("stall_req",   {31'd0, req}, 32'd0);
    end

    // 3-cycle memory with redirect during the request
    zw      = 1'b0;
    man_ack = 1'b0;
    ready   = 1'b1;
    tick();
    redir     = 1'b1;
    redir_tgt = 16'h0040;
    chk("lat_c1_req",  {31'd0, req}, 32'd1);
    chk("lat_c1_addr", {16'd0, addr}, 32'h0002);
    tick();
    redir = 1'b0;
    chk("lat_c2_addr",  {16'd0, addr}, 32'h0002);
    chk("lat_c2_req",   {31'd0, req}, 32'd1);
    chk("lat_c2_valid", {31'd0, vld}, 32'd0);
    tick();
    man_ack   = 1'b1;
    man_rdata = 16'h5555;
    chk("lat_c3_addr", {16'd0, addr}, 32'h0002);
    tick();
    man_ack = 1'b0;
    chk("lat_disc_valid", {31'd0, vld}, 32'd0);
    chk("lat_new_req",    {31'd0, req}, 32'd1);
    chk("lat_new_addr",   {16'd0, addr}, 32'h0040);
    man_ack   = 1'b1;
    man_rdata = 16'h2ABC;
    tick();
    man_ack = 1'b0;
    chk("lat_valid", {31'd0, vld}, 32'd1);
    chk("lat_instr", {16'd0, ins}, 32'h2ABC);
    chk("lat_ipc",   {16'd0, ipc}, 32'h0040);

    // Redirect in S_FULL with simultaneous ready
    redir     = 1'b1;
    redir_tgt = 16'h0100;
    tick();
    redir = 1'b0;
    chk("rfull_valid", {31'd0, vld}, 32'd0);
    chk("rfull_req",   {31'd0, req}, 32'd1);
    chk("rfull_addr",  {16'd0, addr}, 32'h0100);

    // Redirect in S_REQ coinciding with ack
    man_ack   = 1'b1;
    man_rdata = 16'h1111;
    redir     = 1'b1;
    redir_tgt = 16'h0200;
    tick();
    man_ack = 1'b0;
    redir   = 1'b0;
    chk("rack_valid", {31'd0, vld}, 32'd0);
    chk("rack_req",   {31'd0, req}, 32'd1);
    chk("rack_addr",  {16'd0, addr}, 32'h0200);

    // Jump word 0x0ABC at pc 0x1005
    zw        = 1'b1;
    ready     = 1'b0;
    redir     = 1'b1;
    redir_tgt = 16'h1005;
    tick();
    redir = 1'b0;
    chk("jmp_fetch_addr", {16'd0, addr}, 32'h1005);
    tick();
    chk("jmp_valid",  {31'd0, vld}, 32'd1);
    chk("jmp_instr",  {16'd0, ins}, 32'h0ABC);
    chk("jmp_opcode", {28'd0, opc}, 32'h0);
    chk("jmp_ipc",    {16'd0, ipc}, 32'h1005);
`ifdef IFETCH_JUMP_PREDECODE_EN
    chk("jmp_jumped", {31'd0, jmp}, 32'd1);
    exp_next = 16'h1ABC;
`else
    exp_next = 16'h1006;
`endif
    ready = 1'b1;
    tick();
    chk("jmp_next_req",  {31'd0, req}, 32'd1);
    chk("jmp_next_addr", {16'd0, addr}, {16'd0, exp_next});
    tick();
    chk("post_instr", {16'd0, ins}, {16'd0, 16'h3000 | {4'h0, exp_next[11:0]}});
    chk("post_ipc",   {16'd0, ipc}, {16'd0, exp_next});
`ifdef IFETCH_JUMP_PREDECODE_EN
    chk("post_jumped", {31'd0, jmp}, 32'd0);
`endif

    // Reset asserted mid-request
    zw = 1'b0;
    tick();
    chk("mid_req",  {31'd0, req}, 32'd1);
    chk("mid_addr", {16'd0, addr}, {16'd0, exp_next + 16'd1});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   {31'd0, req}, 32'd0);
    chk("mid_rst_addr",  {16'd0, addr}, 32'h0000);
    chk("mid_rst_valid", {31'd0, vld}, 32'd0);
    chk("mid_rst_instr", {16'd0, ins}, 32'h0000);
    chk("mid_rst_ipc",   {16'd0, ipc}, 32'h0000);
    chk("mid_rst_addr2", {16'd0, addr2}, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
